// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the round-robin global-memory controller.
//   chan_state_t : per-channel transaction state
//   STAT_BITS    : width of the optional performance counters
//   idx_bits()   : consumer index width, never less than one bit
//   sat_add()    : saturating add used by the performance counters
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } chan_state_t;

  localparam int unsigned STAT_BITS = 32;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [STAT_BITS-1:0] sat_add(input logic [STAT_BITS-1:0] a,
                                                   input logic [STAT_BITS-1:0] b);
    logic [STAT_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_BITS] ? '1 : s[STAT_BITS-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i   : request vector, one bit per consumer
//   ptr_i   : index at which the scan starts (wraps modulo N)
//   gnt_o   : one-hot grant (all zero when nothing is requested)
//   idx_o   : index of the granted consumer
//   valid_o : a grant was made
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Two ascending passes: first from ptr_i to the top, then wrap to the
  // indices below ptr_i. This is the modulo-N scan without a variable modulo.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      if (!valid_o && req_i[j] && (j >= int'(ptr_i))) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      if (!valid_o && req_i[j] && (j < int'(ptr_i))) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_controller_rr.sv
// Global-memory controller: N consumers share C memory channels with
// round-robin arbitration. Each idle channel picks the next eligible consumer
// from the shared pointer; grants are chained so no consumer is granted twice
// in one cycle. A consumer asserting both read and write is served as a read.
//   clk, reset               : clock, synchronous active-high reset
//   consumer_read_*          : per-consumer read request / response
//   consumer_write_*         : per-consumer write request / completion
//   mem_read_*, mem_write_*  : per-channel memory-side interface
// Optional: define MEM_CTRL_STATS_EN to add stat_reads, stat_writes and
// stat_stall_cycles (saturating 32-bit counters).
module mem_controller_rr
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned NUM_CHANNELS  = 1,
  parameter int unsigned WRITE_ENABLE  = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [STAT_BITS-1:0]                     stat_reads,
  output logic [STAT_BITS-1:0]                     stat_writes,
  output logic [STAT_BITS-1:0]                     stat_stall_cycles
`endif
);

  localparam int unsigned N  = NUM_CONSUMERS;
  localparam int unsigned C  = NUM_CHANNELS;
  localparam int unsigned IW = idx_bits(NUM_CONSUMERS);
  localparam bit          WE = (WRITE_ENABLE != 0);

  chan_state_t                  state_q [C];
  chan_state_t                  state_d [C];
  logic [IW-1:0]                owner_q [C];
  logic [IW-1:0]                owner_d [C];
  logic [N-1:0]                 busy_q, busy_d;
  logic [IW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [N-1:0]                 crr_q, crr_d;
  logic [N-1:0][DATA_BITS-1:0]  crd_q, crd_d;
  logic [N-1:0]                 cwr_q, cwr_d;
  logic [C-1:0]                 mrv_q, mrv_d;
  logic [C-1:0][ADDR_BITS-1:0]  mra_q, mra_d;
  logic [C-1:0]                 mwv_q, mwv_d;
  logic [C-1:0][ADDR_BITS-1:0]  mwa_q, mwa_d;
  logic [C-1:0][DATA_BITS-1:0]  mwd_q, mwd_d;

  logic [N-1:0]                 eligible;
  logic [C-1:0][N-1:0]          remain;
  logic [C-1:0][N-1:0]          ch_req;
  logic [C-1:0][N-1:0]          ch_gnt;
  logic [C-1:0][IW-1:0]         ch_idx;
  logic [C-1:0]                 ch_valid;

  assign eligible = (consumer_read_valid | (WE ? consumer_write_valid : '0)) & ~busy_q;

  // Channel c only sees consumers not already taken by channels below it.
  for (genvar c = 0; c < int'(C); c++) begin : g_arb
    if (c == 0) begin : g_first
      assign remain[c] = eligible;
    end else begin : g_chain
      assign remain[c] = remain[c-1] & ~ch_gnt[c-1];
    end
    assign ch_req[c] = (state_q[c] == IDLE) ? remain[c] : '0;

    rr_arbiter #(
      .N  (N),
      .IW (IW)
    ) u_arb (
      .req_i   (ch_req[c]),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (ch_gnt[c]),
      .idx_o   (ch_idx[c]),
      .valid_o (ch_valid[c])
    );
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    rr_ptr_d = rr_ptr_q;
    crr_d    = crr_q;
    crd_d    = crd_q;
    cwr_d    = cwr_q;
    mrv_d    = mrv_q;
    mra_d    = mra_q;
    mwv_d    = mwv_q;
    mwa_d    = mwa_q;
    mwd_d    = mwd_q;
    for (int c = 0; c < int'(C); c++) begin
      case (state_q[c])
        IDLE: begin
          if (ch_valid[c]) begin
            owner_d[c]         = ch_idx[c];
            busy_d[ch_idx[c]]  = 1'b1;
            // Later channels overwrite, so the pointer follows the last grant.
            rr_ptr_d = (ch_idx[c] == IW'(N - 1)) ? '0 : ch_idx[c] + IW'(1);
            if (consumer_read_valid[ch_idx[c]]) begin
              state_d[c] = READ_WAITING;
              mrv_d[c]   = 1'b1;
              mra_d[c]   = consumer_read_address[ch_idx[c]];
            end else begin
              state_d[c] = WRITE_WAITING;
              mwv_d[c]   = 1'b1;
              mwa_d[c]   = consumer_write_address[ch_idx[c]];
              mwd_d[c]   = consumer_write_data[ch_idx[c]];
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[c]) begin
            mrv_d[c]          = 1'b0;
            crr_d[owner_q[c]] = 1'b1;
            crd_d[owner_q[c]] = mem_read_data[c];
            state_d[c]        = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[c]) begin
            mwv_d[c]          = 1'b0;
            cwr_d[owner_q[c]] = 1'b1;
            state_d[c]        = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[owner_q[c]]) begin
            crr_d[owner_q[c]]  = 1'b0;
            busy_d[owner_q[c]] = 1'b0;
            state_d[c]         = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[owner_q[c]]) begin
            cwr_d[owner_q[c]]  = 1'b0;
            busy_d[owner_q[c]] = 1'b0;
            state_d[c]         = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= '{default: IDLE};
      owner_q  <= '{default: '0};
      busy_q   <= '0;
      rr_ptr_q <= '0;
      crr_q    <= '0;
      crd_q    <= '0;
      cwr_q    <= '0;
      mrv_q    <= '0;
      mra_q    <= '0;
      mwv_q    <= '0;
      mwa_q    <= '0;
      mwd_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      crr_q    <= crr_d;
      crd_q    <= crd_d;
      cwr_q    <= cwr_d;
      mrv_q    <= mrv_d;
      mra_q    <= mra_d;
      mwv_q    <= mwv_d;
      mwa_q    <= mwa_d;
      mwd_q    <= mwd_d;
    end
  end

  assign consumer_read_ready  = crr_q;
  assign consumer_read_data   = crd_q;
  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  // Read-only builds hold the whole write side at zero.
  assign consumer_write_ready = WE ? cwr_q : '0;
  assign mem_write_valid      = WE ? mwv_q : '0;
  assign mem_write_address    = WE ? mwa_q : '0;
  assign mem_write_data       = WE ? mwd_q : '0;

`ifdef MEM_CTRL_STATS_EN
  logic [STAT_BITS-1:0] reads_q, writes_q, stall_q;
  logic [C-1:0]         rd_done, wr_done;
  logic                 any_idle;

  // A transaction completes when its channel leaves RELAYING.
  always_comb begin
    rd_done  = '0;
    wr_done  = '0;
    any_idle = 1'b0;
    for (int c = 0; c < int'(C); c++) begin
      rd_done[c] = (state_q[c] == READ_RELAYING) && !consumer_read_valid[owner_q[c]];
      wr_done[c] = (state_q[c] == WRITE_RELAYING) && !consumer_write_valid[owner_q[c]];
      if (state_q[c] == IDLE) any_idle = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reads_q  <= '0;
      writes_q <= '0;
      stall_q  <= '0;
    end else begin
      reads_q  <= sat_add(reads_q, STAT_BITS'($countones(rd_done)));
      writes_q <= sat_add(writes_q, STAT_BITS'($countones(wr_done)));
      stall_q  <= sat_add(stall_q, {{(STAT_BITS-1){1'b0}}, (|eligible) && !any_idle});
    end
  end

  assign stat_reads        = reads_q;
  assign stat_writes       = writes_q;
  assign stat_stall_cycles = stall_q;
`endif

endmodule
